// File: rtl/prio_arb_pkg.sv
// Shared definitions for the N-way priority arbiter: FSM state encoding,
// default sizing constants and a one-hot helper.
package prio_arb_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_PW = 2;
  localparam int MAX_N  = 16;
  localparam int MAX_IW = $clog2(MAX_N);

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

  // One-hot vector with bit idx set, sized for the largest supported N.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IW-1:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_arb_pick.sv
// Combinational winner selection: highest priority among requesters, ties
// resolved by scanning upward from rr_ptr with wrap-around.
module prio_arb_pick
  import prio_arb_pkg::*;
#(
  parameter  int N   = DEF_N,
  parameter  int PW  = DEF_PW,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N*PW-1:0] prio,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            any,
  output logic [IDW-1:0]  win_id
);

  localparam int SW = IDW + 1;

  logic [PW-1:0]  p [N];
  logic [PW-1:0]  best;
  logic [SW-1:0]  sum;
  logic [IDW-1:0] idx;
  logic           found;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign p[i] = prio[i*PW +: PW];
  end

  // Find the top priority, then the first requester holding it from rr_ptr on.
  always_comb begin
    // NOTE: every variable gets a value before any conditional update so no latch is inferred.
    any    = |req;
    best   = '0;
    found  = 1'b0;
    win_id = '0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (p[i] > best)) best = p[i];
    end
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      idx = (sum >= SW'(N)) ? IDW'(sum - SW'(N)) : IDW'(sum);
      if (!found && req[idx] && (p[idx] == best)) begin
        win_id = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_n.sv
// N-requester priority arbiter with round-robin tie breaking and a grant
// held until the owner drops its request. Optional preemption by a strictly
// higher-priority requester is enabled with `define PRIO_ARB_PREEMPT_EN.
module prio_arbiter_n
  import prio_arb_pkg::*;
#(
  parameter  int N   = DEF_N,
  parameter  int PW  = DEF_PW,
  localparam int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*PW-1:0] prio,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id
);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] next_ptr;
  logic [IDW-1:0] pick_ptr;
  logic [IDW-1:0] win_id;
  logic [N-1:0]   win_oh;
  logic           any;
  logic           own_drop;
  logic           preempt;

  // The owner letting go advances the pointer, and the replacement winner is
  // chosen against that advanced pointer in the same cycle.
  assign own_drop = (state == BUSY) && !req[gnt_id];
  assign next_ptr = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + IDW'(1);
  assign pick_ptr = own_drop ? next_ptr : rr_ptr;
  assign win_oh   = N'(onehot(MAX_IW'(win_id)));

  prio_arb_pick #(.N(N), .PW(PW)) u_pick (
    .req    (req),
    .prio   (prio),
    .rr_ptr (pick_ptr),
    .any    (any),
    .win_id (win_id)
  );

`ifdef PRIO_ARB_PREEMPT_EN
  logic [PW-1:0] p [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign p[i] = prio[i*PW +: PW];
  end

  // A held grant moves only to a strictly higher priority winner.
  assign preempt = (state == BUSY) && !own_drop && any && (p[win_id] > p[gnt_id]);
`else
  assign preempt = 1'b0;
`endif

  // FSM, grant registers and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (own_drop) rr_ptr <= next_ptr;
      if ((state == IDLE) || own_drop || preempt) begin
        if (any) begin
          state     <= BUSY;
          gnt       <= win_oh;
          gnt_valid <= 1'b1;
          gnt_id    <= win_id;
        end else begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          gnt_id    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Scoreboard bench for prio_arbiter_n: directed scenarios plus random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_prio_arbiter_n;

  localparam int N  = 4;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*PW-1:0] prio = '0;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [1:0]      gnt_id;

  always #5 clk = ~clk;

  prio_arbiter_n #(.N(N), .PW(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .prio      (prio),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         valid;
    logic [1:0]   id;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   m_owner = -1;
  int   m_ptr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pri(input logic [N*PW-1:0] p, input int i);
    return int'(p[i*PW +: PW]);
  endfunction

  // Requester with the highest priority; ties go to the first at or after ptr.
  function automatic int arb(input logic [N-1:0] r, input logic [N*PW-1:0] p, input int ptr);
    int best = -1;
    for (int i = 0; i < N; i++)
      if (r[i] && pri(p, i) > best) best = pri(p, i);
    if (best < 0) return -1;
    for (int k = 0; k < N; k++) begin
      int j = (ptr + k) % N;
      if (r[j] && pri(p, j) == best) return j;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs and push the model's post-edge expectation.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*PW-1:0] pv);
    exp_t e;
    int   w;
    @(negedge clk);
    rst  = r;
    req  = rq;
    prio = pv;
    w    = -1;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      m_owner = arb(rq, pv, m_ptr);
    end else if (!rq[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = arb(rq, pv, m_ptr);
    end
`ifdef PRIO_ARB_PREEMPT_EN
    else begin
      w = arb(rq, pv, m_ptr);
      if (w >= 0 && pri(pv, w) > pri(pv, m_owner)) m_owner = w;
    end
`endif
    e.gnt   = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    e.valid = (m_owner >= 0);
    e.id    = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    sb.push_back(e);
  endtask

  // Direct check of the grant produced by the edge following the last step.
  task automatic expect_g(input string name, input logic [N-1:0] g, input logic [1:0] id);
    @(posedge clk);
    #2;
    check({name, ".gnt"}, 32'(gnt), 32'(g));
    check({name, ".id"}, 32'(gnt_id), 32'(id));
  endtask

  // Monitor: compare every registered output against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb.gnt", 32'(gnt), 32'(e.gnt));
        check("sb.valid", 32'(gnt_valid), 32'(e.valid));
        check("sb.id", 32'(gnt_id), 32'(e.id));
        check("sb.valid_is_or", 32'(gnt_valid), 32'(|gnt));
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    // Reset with all requests high.
    step(1'b1, 4'b1111, 8'h55);  expect_g("reset", 4'b0000, 2'd0);
    check("reset.valid", 32'(gnt_valid), 32'd0);
    // Priority win, hold even when prio[0] ties the owner.
    step(1'b0, 4'b1111, 8'hC9);  expect_g("prio_win", 4'b1000, 2'd3);
    step(1'b0, 4'b1111, 8'hCB);  expect_g("prio_hold", 4'b1000, 2'd3);
    step(1'b0, 4'b1111, 8'hCB);  expect_g("prio_hold2", 4'b1000, 2'd3);
    // Reset mid-grant.
    step(1'b1, 4'b1111, 8'hCB);  expect_g("reset_mid", 4'b0000, 2'd0);
    // Round-robin at equal priority, no idle bubble.
    step(1'b0, 4'b1111, 8'h55);  expect_g("rr0", 4'b0001, 2'd0);
    step(1'b0, 4'b1110, 8'h55);  expect_g("rr1", 4'b0010, 2'd1);
    step(1'b0, 4'b1101, 8'h55);  expect_g("rr2", 4'b0100, 2'd2);
    step(1'b0, 4'b1011, 8'h55);  expect_g("rr3", 4'b1000, 2'd3);
    step(1'b0, 4'b0111, 8'h55);  expect_g("rr4", 4'b0001, 2'd0);
    // Handover to idle, then scan resumes after the last owner.
    step(1'b0, 4'b0000, 8'h55);  expect_g("idle0", 4'b0000, 2'd0);
    step(1'b0, 4'b0010, 8'h55);  expect_g("own1", 4'b0010, 2'd1);
    step(1'b0, 4'b0000, 8'h55);  expect_g("idle1", 4'b0000, 2'd0);
    step(1'b0, 4'b0101, 8'h55);  expect_g("scan_from2", 4'b0100, 2'd2);
    // Wrap from owner 3 back to requester 0.
    step(1'b0, 4'b1000, 8'h55);  expect_g("own3", 4'b1000, 2'd3);
    step(1'b0, 4'b0011, 8'h55);  expect_g("wrap", 4'b0001, 2'd0);
    // Higher-priority arrival against owner 1, then an equal-priority one.
    step(1'b0, 4'b0010, 8'h55);  expect_g("own1b", 4'b0010, 2'd1);
    step(1'b0, 4'b0110, 8'h65);
`ifdef PRIO_ARB_PREEMPT_EN
    expect_g("preempt", 4'b0100, 2'd2);
    step(1'b0, 4'b0111, 8'h55);  expect_g("eq_no_preempt", 4'b0100, 2'd2);
`else
    expect_g("no_preempt", 4'b0010, 2'd1);
    step(1'b0, 4'b0111, 8'h55);  expect_g("eq_no_preempt", 4'b0010, 2'd1);
`endif
    // Random traffic: requests tend to persist so grants are held for a while.
    rq = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      else if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, N-1)] = 1'b0;
      step(($urandom_range(0, 63) == 0), rq, 8'($urandom));
    end
    // Drain the scoreboard within a bounded number of cycles.
    for (int c = 0; c < 4 && sb.size() > 0; c++) @(posedge clk);
    #3;
    check("drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
